pds_alloc_ctrl: RTL and testbench

PDS_ALLOC_CTRL -- requirements
Module: pds_alloc_ctrl

---
 rtl/pds_alloc_ctrl.sv | 141 ++++++++++++++
 tb/tb_pds_alloc_ctrl.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/pds_alloc_ctrl.sv
// PoE power allocator: scans eligible ports by priority against a latched budget,
// commits the grant set, then ramps new ports on one at a time with an inrush delay.
module pds_alloc_ctrl #(
    parameter int unsigned numPorts   = 4,
    parameter int unsigned PORT_PWR   = 30,
    parameter int unsigned INRUSH_DLY = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [numPorts-1:0]   det,
    input  logic [numPorts-1:0]   off,
    input  logic [2*numPorts-1:0] prio,
    input  logic [7:0]            pwr_bdj,
    input  logic                  ports_off,
    output logic [numPorts-1:0]   on,
    output logic [8:0]            pwr_used
);
    localparam int unsigned      PortW    = (numPorts > 1) ? $clog2(numPorts) : 1;
    localparam logic [9:0]       PwrInc   = 10'(PORT_PWR);
    localparam logic [7:0]       DlyLoad  = 8'(INRUSH_DLY - 1);
    localparam logic [PortW-1:0] LastPort = PortW'(numPorts - 1);

    typedef enum logic [2:0] {StIdle, StScan, StCommit, StRamp, StOff} state_e;

    state_e              state_q;
    logic [numPorts-1:0] on_q, pending_q, target_q;
    logic [8:0]          used_q, pwr_used_q, budget_q;
    logic [7:0]          dly_q;
    logic [1:0]          lvl_q;
    logic [PortW-1:0]    port_q;

    logic [numPorts-1:0] keep, scan_sel, ramp_sel, commit_pend, ramp_pend;
    logic [1:0]          port_prio;
    logic [9:0]          used_sum;
    logic                scan_grant, scan_start, found;

    assign on       = on_q;
    assign pwr_used = pwr_used_q;

    // Ports that survive this edge; anything else is dropped immediately.
    assign keep     = det & ~off;
    assign used_sum = {1'b0, used_q} + PwrInc;

    always_comb begin
        scan_sel  = '0;
        port_prio = 2'd0;
        for (int i = 0; i < numPorts; i++) begin
            if (port_q == PortW'(i)) begin
                scan_sel[i] = 1'b1;
                port_prio   = prio[2*i +: 2];
            end
        end
    end

    always_comb begin
        ramp_sel = '0;
        found    = 1'b0;
        for (int i = 0; i < numPorts; i++) begin
            if (pending_q[i] && !found) begin
                ramp_sel[i] = 1'b1;
                found       = 1'b1;
            end
        end
    end

    assign scan_grant  = (|(scan_sel & keep)) && (port_prio == lvl_q) &&
                         (used_sum <= {1'b0, budget_q});
    assign commit_pend = target_q & ~on_q & keep;
    assign ramp_pend   = ((dly_q == 8'd0) ? (pending_q & ~ramp_sel) : pending_q) & keep;
    assign scan_start  = (state_q == StIdle) ||
                         ((state_q == StCommit) && (commit_pend == '0)) ||
                         ((state_q == StRamp) && (ramp_pend == '0));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            on_q       <= '0;
            pending_q  <= '0;
            target_q   <= '0;
            used_q     <= '0;
            pwr_used_q <= '0;
            budget_q   <= '0;
            dly_q      <= '0;
            lvl_q      <= '0;
            port_q     <= '0;
        end else if (ports_off) begin
            state_q    <= StOff;
            on_q       <= '0;
            pending_q  <= '0;
            pwr_used_q <= '0;
        end else begin
            on_q      <= on_q & keep;
            pending_q <= pending_q & keep;
            unique case (state_q)
                StIdle: state_q <= StScan;
                StScan: begin
                    if (scan_grant) begin
                        target_q <= target_q | scan_sel;
                        used_q   <= used_sum[8:0];
                    end
                    if (port_q == LastPort) begin
                        port_q <= '0;
                        lvl_q  <= lvl_q - 2'd1;
                        if (lvl_q == 2'd0) state_q <= StCommit;
                    end else begin
                        port_q <= port_q + PortW'(1);
                    end
                end
                StCommit: begin
                    on_q       <= on_q & target_q & keep;
                    pending_q  <= commit_pend;
                    pwr_used_q <= used_q;
                    dly_q      <= DlyLoad;
                    state_q    <= (commit_pend != '0) ? StRamp : StScan;
                end
                StRamp: begin
                    pending_q <= ramp_pend;
                    if (dly_q == 8'd0) begin
                        on_q  <= (on_q | ramp_sel) & keep;
                        dly_q <= DlyLoad;
                    end else begin
                        dly_q <= dly_q - 8'd1;
                    end
                    if (ramp_pend == '0) state_q <= StScan;
                end
                StOff:   state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
            // Every entry into a scan round starts from a fresh budget snapshot.
            if (scan_start) begin
                state_q  <= StScan;
                budget_q <= {1'b0, pwr_bdj};
                used_q   <= '0;
                target_q <= '0;
                lvl_q    <= 2'd3;
                port_q   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_pds_alloc_ctrl.sv
// Directed bench for pds_alloc_ctrl: fixed-cycle scenarios with hand-computed on/pwr_used.
module tb_pds_alloc_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] det, off;
    logic [7:0] prio;
    logic [7:0] pwr_bdj;
    logic       ports_off;
    logic [3:0] on;
    logic [8:0] pwr_used;

    int n_tests = 0;
    int n_fail  = 0;

    pds_alloc_ctrl #(
        .numPorts  (4),
        .PORT_PWR  (30),
        .INRUSH_DLY(4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .det      (det),
        .off      (off),
        .prio     (prio),
        .pwr_bdj  (pwr_bdj),
        .ports_off(ports_off),
        .on       (on),
        .pwr_used (pwr_used)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        check("rst_on", 16'(on), 16'h0);
        check("rst_pwr", 16'(pwr_used), 16'd0);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; det = 4'hF; off = 4'h0; prio = 8'h00; pwr_bdj = 8'd255; ports_off = 1'b0;

        // Full budget: commit at edge 18, turn-ons at 22/26/30/34.
        do_reset();
        tick(18);
        check("full_commit_pwr", 16'(pwr_used), 16'd120);
        check("full_commit_on", 16'(on), 16'h0);
        tick(3);
        check("full_e21", 16'(on), 16'h0);
        tick(1);
        check("full_e22", 16'(on), 16'h1);
        tick(4);
        check("full_e26", 16'(on), 16'h3);
        tick(4);
        check("full_e30", 16'(on), 16'h7);
        tick(4);
        check("full_e34", 16'(on), 16'hF);

        // Global off for 3 edges, then a fresh ramp from port0.
        ports_off = 1'b1;
        tick(1);
        check("goff_on", 16'(on), 16'h0);
        check("goff_pwr", 16'(pwr_used), 16'd0);
        tick(2);
        check("goff_hold", 16'(on), 16'h0);
        ports_off = 1'b0;
        tick(19);
        check("goff_commit_pwr", 16'(pwr_used), 16'd120);
        tick(3);
        check("goff_f22", 16'(on), 16'h0);
        tick(1);
        check("goff_f23", 16'(on), 16'h1);
        tick(12);
        check("goff_f35", 16'(on), 16'hF);

        // Budget drop: current round keeps old budget, next commit applies 30.
        pwr_bdj = 8'd30;
        tick(17);
        check("drop_old_on", 16'(on), 16'hF);
        check("drop_old_pwr", 16'(pwr_used), 16'd120);
        tick(17);
        check("drop_new_on", 16'(on), 16'h1);
        check("drop_new_pwr", 16'(pwr_used), 16'd30);

        // Priority cut: budget 70 admits port3 (prio 3) then port1 (prio 2).
        pwr_bdj = 8'd70; prio = 8'hC9;
        do_reset();
        tick(18);
        check("prio_pwr", 16'(pwr_used), 16'd60);
        tick(4);
        check("prio_e22", 16'(on), 16'h2);
        tick(4);
        check("prio_e26", 16'(on), 16'hA);
        tick(24);
        check("prio_stable", 16'(on), 16'hA);

        // Tie and skip: ports 0,1 granted; disabling port0 lets port2 in next round.
        pwr_bdj = 8'd60; prio = 8'h55;
        do_reset();
        tick(26);
        check("tie_e26", 16'(on), 16'h3);
        off = 4'h1;
        tick(1);
        check("tie_fast_off", 16'(on), 16'h2);
        tick(16);
        check("tie_commit_on", 16'(on), 16'h2);
        check("tie_commit_pwr", 16'(pwr_used), 16'd60);
        tick(3);
        check("tie_e46", 16'(on), 16'h2);
        tick(1);
        check("tie_e47", 16'(on), 16'h6);

        // Reset mid-ramp after second turn-on.
        off = 4'h0; prio = 8'h00; pwr_bdj = 8'd255;
        do_reset();
        tick(26);
        check("rstmid_e26", 16'(on), 16'h3);
        rst = 1'b1;
        tick(1);
        check("rstmid_on", 16'(on), 16'h0);
        check("rstmid_pwr", 16'(pwr_used), 16'd0);
        rst = 1'b0;
        tick(21);
        check("rstmid_r21", 16'(on), 16'h0);
        tick(1);
        check("rstmid_r22", 16'(on), 16'h1);

        // Disconnect on the edge port1 would turn on; ramp moves on to port2.
        do_reset();
        tick(25);
        det = 4'b1101;
        tick(1);
        check("disc_e26", 16'(on), 16'h1);
        tick(3);
        check("disc_e29", 16'(on), 16'h1);
        tick(1);
        check("disc_e30", 16'(on), 16'h5);
        tick(4);
        check("disc_e34", 16'(on), 16'hD);

        // Global off and disconnect on the same edge.
        ports_off = 1'b1; off = 4'h1;
        tick(1);
        check("both_off", 16'(on), 16'h0);
        ports_off = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
